control_frec_dpwm: RTL and testbench
====================================

# control_frec_dpwm

Synchronous frequency-selection controller for the DPWM. It conditions the raw up/down push-buttons with a 2-FF synchronizer, a debounce FSM and an edge detector, and keeps a saturating 3-bit frequency index. It drives the DPWM period timebase from that index. A new index is applied only at a period boundary, so the PWM never sees a truncated or stretched period.

## Interface
- `DEBOUNCE_CNT`, default 50000: consecutive stable cycles required to accept a button level change (1 ms at 50 MHz); legal range 2..65535.
- `BASE_DIV`, default 4: period in cycles at index 7; period for index k is `BASE_DIV << (7-k)`.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `boton_aumento` in 1: raw asynchronous button to increase the index (active high).
- `boton_disminuye` in 1: raw asynchronous button to decrease the index (active high).
- `enable` in 1: when low, accepted presses are discarded and not queued; the timebase keeps running.
- `numero_frec` out 3: index currently applied to the timebase.
- `tick_frec` out 1: one-cycle pulse on the last cycle of each period.
- `cambio_pend` out 1: high while the requested index differs from `numero_frec`.
- `saturacion` out 1: one-cycle pulse when a press is rejected because the index is at a limit.

## Operation
- Synchronizer: two flops per button, with no reset dependence on the data path. Both flops clear on `reset`.
- Debounce FSM, one per button. States are SOLTADO, VALID_PRES, PRESIONADO and VALID_SOLT.
  - SOLTADO → VALID_PRES when the synced input is 1; the counter clears.
  - VALID_PRES: the counter increments while the input is 1. When the counter reaches DEBOUNCE_CNT-1, go to PRESIONADO and emit a one-cycle press pulse. If the input returns to 0, go back to SOLTADO.
  - PRESIONADO → VALID_SOLT when the input is 0. Release is validated symmetrically back to SOLTADO, with no pulse.
  - A held button produces exactly one pulse, with no auto-repeat.
- Requested index `sel_pend` (internal, 3 bits):
  - Up pulse: +1 if `sel_pend` < 7; otherwise no change and `saturacion` pulses.
  - Down pulse: -1 if `sel_pend` > 0; otherwise no change and `saturacion` pulses.
  - Up and down pulses in the same cycle: both are ignored, with no change and no `saturacion`.
  - `enable` = 0: pulses are ignored, with no `saturacion`.
  - The index never wraps.
- Timebase: a 16-bit counter `cnt` counts 0..P-1, where P = `BASE_DIV << (7-numero_frec)`.
  - On the cycle where `cnt` = P-1: `tick_frec` = 1, `cnt` ← 0, and `numero_frec` ← `sel_pend`.
  - The new P takes effect from the next period.
- `cambio_pend` = (`sel_pend` != `numero_frec`), registered.
- Reset values: `numero_frec`=0, `sel_pend`=0, `cnt`=0, `tick_frec`=0, `cambio_pend`=0, `saturacion`=0. Both FSMs go to SOLTADO and both synchronizers clear.
- Reset mid-period discards any pending change and restarts a full index-0 period.

## Timing
- All outputs are registered.
- Press latency: number edges from 1, where edge 1 is the first edge sampling the raw input high. The press pulse is registered at edge DEBOUNCE_CNT+2, `sel_pend` updates at edge DEBOUNCE_CNT+3, and `cambio_pend` rises at edge DEBOUNCE_CNT+4.
- Apply latency: `numero_frec` updates on the edge that ends the current period. Worst case this is P_old cycles after `sel_pend` changes.
- `tick_frec` pulses are exactly P cycles apart within a constant index. Across an index change, the gap equals the old P, and the following gaps use the new P.
- Multiple presses within one period: only the final `sel_pend` is applied at the boundary.
- `cambio_pend` falls one cycle after the boundary edge that updates `numero_frec`.
- `saturacion` follows the rejected press pulse by one cycle, the same cycle `sel_pend` would have updated.

## Test plan
Use DEBOUNCE_CNT=4 and BASE_DIV=4 for simulation.
- **Reset:** hold `reset` 3 cycles, then release, with buttons low. Outputs are 0 and the first `tick_frec` comes 512 cycles after release; the next comes 512 cycles later.
- **Clean up-press:** raise `boton_aumento` for 20 cycles. `cambio_pend` rises at edge 8. At the next tick, `numero_frec` goes to 1 and `cambio_pend` falls; tick spacing becomes 256.
- **Bounce:** toggle `boton_disminuye` as 3 cycles high / 2 cycles low ten times at index 3. There are no press pulses, and `sel_pend` and `numero_frec` stay at 3.
- **Saturation:** from reset, issue 8 clean up-presses. `numero_frec` ends at 7 with tick spacing 4, and the 8th press produces one `saturacion` pulse. Then issue 8 down-presses: the index reaches 0 and the 8th press pulses `saturacion`.
- **Conflict and enable:** drive both buttons identically so both pulses coincide; there is no change and no `saturacion`. An up-press with `enable`=0 causes no change. Raising `enable` while the button is still held does not retroactively apply the press.
- **Reset mid-operation:** at index 5, press up, then assert `reset` while `cambio_pend`=1. The cycle after, all outputs are 0, the pending change is lost, and the next tick comes 512 cycles later.

Source files
------------

// File: rtl/control_frec_dpwm.sv
// DPWM frequency-selection controller: button conditioning, saturating index,
// and a period timebase that only adopts a new index at a period boundary.
module control_frec_antirrebote #(
  parameter int unsigned DEBOUNCE_CNT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic boton,
  output logic pulso
);

  typedef enum logic [1:0] {
    SOLTADO,
    VALID_PRES,
    PRESIONADO,
    VALID_SOLT
  } estado_t;

  // counter hits DEBOUNCE_CNT-1 on the same edge that accepts the level
  localparam logic [15:0] CNT_FIN = 16'(DEBOUNCE_CNT - 2);

  logic        s1;
  logic        s2;
  logic [15:0] cnt;
  estado_t     estado;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      estado <= SOLTADO;
      pulso  <= 1'b0;
    end else begin
      s1    <= boton;
      s2    <= s1;
      pulso <= 1'b0;
      unique case (estado)
        SOLTADO: begin
          if (s2) begin
            estado <= VALID_PRES;
            cnt    <= '0;
          end
        end
        VALID_PRES: begin
          if (!s2) begin
            estado <= SOLTADO;
          end else if (cnt == CNT_FIN) begin
            estado <= PRESIONADO;
            pulso  <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        PRESIONADO: begin
          if (!s2) begin
            estado <= VALID_SOLT;
            cnt    <= '0;
          end
        end
        VALID_SOLT: begin
          if (s2) begin
            estado <= PRESIONADO;
          end else if (cnt == CNT_FIN) begin
            estado <= SOLTADO;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: estado <= SOLTADO;
      endcase
    end
  end

endmodule

module control_frec_dpwm #(
  parameter int unsigned DEBOUNCE_CNT = 50000,
  parameter int unsigned BASE_DIV     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boton_aumento,
  input  logic       boton_disminuye,
  input  logic       enable,
  output logic [2:0] numero_frec,
  output logic       tick_frec,
  output logic       cambio_pend,
  output logic       saturacion
);

  logic        pulso_up;
  logic        pulso_dn;
  logic [2:0]  sel_pend;
  logic [15:0] cnt;
  logic [15:0] periodo;
  logic        fin;

  control_frec_antirrebote #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_ar_up (
    .clk  (clk),
    .reset(reset),
    .boton(boton_aumento),
    .pulso(pulso_up)
  );

  control_frec_antirrebote #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_ar_dn (
    .clk  (clk),
    .reset(reset),
    .boton(boton_disminuye),
    .pulso(pulso_dn)
  );

  assign periodo = 16'(BASE_DIV) << (3'd7 - numero_frec);
  assign fin     = (cnt == periodo - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_pend    <= '0;
      numero_frec <= '0;
      cnt         <= '0;
      tick_frec   <= 1'b0;
      cambio_pend <= 1'b0;
      saturacion  <= 1'b0;
    end else begin
      saturacion <= 1'b0;
      // simultaneous up/down presses cancel out
      if (enable && (pulso_up ^ pulso_dn)) begin
        if (pulso_up) begin
          if (sel_pend != 3'd7) sel_pend <= sel_pend + 3'd1;
          else                  saturacion <= 1'b1;
        end else begin
          if (sel_pend != 3'd0) sel_pend <= sel_pend - 3'd1;
          else                  saturacion <= 1'b1;
        end
      end
      tick_frec   <= fin;
      cambio_pend <= (sel_pend != numero_frec);
      if (fin) begin
        cnt         <= '0;
        numero_frec <= sel_pend;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_control_frec_dpwm.sv
// Directed bench for control_frec_dpwm with DEBOUNCE_CNT=4, BASE_DIV=4.
module tb_control_frec_dpwm;

  logic       clk = 1'b0;
  logic       reset;
  logic       boton_aumento;
  logic       boton_disminuye;
  logic       enable;
  logic [2:0] numero_frec;
  logic       tick_frec;
  logic       cambio_pend;
  logic       saturacion;

  int checks   = 0;
  int failures = 0;
  int sat_cnt  = 0;
  int sat_base;
  int n;

  control_frec_dpwm #(
    .DEBOUNCE_CNT(4),
    .BASE_DIV    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .boton_aumento  (boton_aumento),
    .boton_disminuye(boton_disminuye),
    .enable         (enable),
    .numero_frec    (numero_frec),
    .tick_frec      (tick_frec),
    .cambio_pend    (cambio_pend),
    .saturacion     (saturacion)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (saturacion === 1'b1) sat_cnt++;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while (tick_frec !== 1'b1 && cyc < 2000);
  endtask

  task automatic press_up();
    boton_aumento = 1'b1;
    step(10);
    boton_aumento = 1'b0;
    step(10);
  endtask

  task automatic press_dn();
    boton_disminuye = 1'b1;
    step(10);
    boton_disminuye = 1'b0;
    step(10);
  endtask

  initial begin
    reset = 1'b1;
    boton_aumento = 1'b0;
    boton_disminuye = 1'b0;
    enable = 1'b1;

    // reset
    step(3);
    chk("rst_numero", int'(numero_frec), 0);
    chk("rst_tick", int'(tick_frec), 0);
    chk("rst_cambio", int'(cambio_pend), 0);
    chk("rst_sat", int'(saturacion), 0);
    reset = 1'b0;
    wait_tick(n);
    chk("first_tick_gap", n, 512);
    chk("first_tick_numero", int'(numero_frec), 0);
    wait_tick(n);
    chk("second_tick_gap", n, 512);

    // clean up-press
    boton_aumento = 1'b1;
    step(7);
    chk("up_cambio_e7", int'(cambio_pend), 0);
    step(1);
    chk("up_cambio_e8", int'(cambio_pend), 1);
    step(12);
    boton_aumento = 1'b0;
    wait_tick(n);
    chk("up_apply_gap", n, 492);
    chk("up_apply_numero", int'(numero_frec), 1);
    chk("up_apply_cambio", int'(cambio_pend), 1);
    step(1);
    chk("up_cambio_fall", int'(cambio_pend), 0);
    chk("tick_one_cycle", int'(tick_frec), 0);
    wait_tick(n);
    chk("idx1_gap_a", n, 255);
    wait_tick(n);
    chk("idx1_gap_b", n, 256);

    // bounce at index 3
    press_up();
    press_up();
    wait_tick(n);
    chk("idx3_numero", int'(numero_frec), 3);
    sat_base = sat_cnt;
    for (int i = 0; i < 10; i++) begin
      boton_disminuye = 1'b1;
      step(3);
      boton_disminuye = 1'b0;
      step(2);
    end
    step(10);
    chk("bounce_cambio", int'(cambio_pend), 0);
    wait_tick(n);
    chk("bounce_numero", int'(numero_frec), 3);
    chk("bounce_sat", sat_cnt - sat_base, 0);

    // saturation going up
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    sat_base = sat_cnt;
    for (int i = 0; i < 7; i++) press_up();
    chk("sat_up_none_yet", sat_cnt - sat_base, 0);
    boton_aumento = 1'b1;
    step(6);
    chk("sat_up_e6", int'(saturacion), 0);
    step(1);
    chk("sat_up_e7", int'(saturacion), 1);
    step(1);
    chk("sat_up_e8", int'(saturacion), 0);
    step(2);
    boton_aumento = 1'b0;
    step(10);
    chk("sat_up_count", sat_cnt - sat_base, 1);
    wait_tick(n);
    chk("idx7_numero", int'(numero_frec), 7);
    wait_tick(n);
    chk("idx7_gap", n, 4);

    // saturation going down
    sat_base = sat_cnt;
    for (int i = 0; i < 7; i++) press_dn();
    chk("sat_dn_none_yet", sat_cnt - sat_base, 0);
    boton_disminuye = 1'b1;
    step(7);
    chk("sat_dn_e7", int'(saturacion), 1);
    step(3);
    boton_disminuye = 1'b0;
    step(10);
    chk("sat_dn_count", sat_cnt - sat_base, 1);
    wait_tick(n);
    chk("idx0_numero", int'(numero_frec), 0);
    wait_tick(n);
    chk("idx0_gap", n, 512);

    // conflict and enable
    sat_base = sat_cnt;
    boton_aumento = 1'b1;
    boton_disminuye = 1'b1;
    step(10);
    chk("conflict_cambio", int'(cambio_pend), 0);
    boton_aumento = 1'b0;
    boton_disminuye = 1'b0;
    step(10);
    chk("conflict_sat", sat_cnt - sat_base, 0);
    enable = 1'b0;
    boton_aumento = 1'b1;
    step(10);
    chk("disabled_cambio", int'(cambio_pend), 0);
    enable = 1'b1;
    step(10);
    chk("late_enable_cambio", int'(cambio_pend), 0);
    boton_aumento = 1'b0;
    step(10);
    chk("enable_sat", sat_cnt - sat_base, 0);
    wait_tick(n);
    chk("enable_numero", int'(numero_frec), 0);

    // reset with a pending change at index 5
    for (int i = 0; i < 5; i++) press_up();
    wait_tick(n);
    chk("idx5_numero", int'(numero_frec), 5);
    boton_aumento = 1'b1;
    step(8);
    chk("mid_cambio", int'(cambio_pend), 1);
    boton_aumento = 1'b0;
    reset = 1'b1;
    step(1);
    chk("mid_rst_numero", int'(numero_frec), 0);
    chk("mid_rst_tick", int'(tick_frec), 0);
    chk("mid_rst_cambio", int'(cambio_pend), 0);
    chk("mid_rst_sat", int'(saturacion), 0);
    reset = 1'b0;
    wait_tick(n);
    chk("mid_rst_gap", n, 512);
    chk("mid_rst_numero_after", int'(numero_frec), 0);
    chk("mid_rst_cambio_after", int'(cambio_pend), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
